// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide synchronous RAM between an instruction-fetch port
//   (read-only) and a data load/store port. Each 32-bit word moves as four
//   little-endian byte beats at base+0..base+3, where base = {addr[11:2],2'b00}.
//
//   Sequence: IDLE -> BEAT x4 -> (FLUSH on reads) -> RESP -> IDLE.
//   Counting from the acceptance edge as cycle 0, a write acks in cycle 5
//   and a read acks in cycle 6.
//
// Ports
//   clk, rst              : clock; asynchronous active-high reset
//   if_req/if_addr        : fetch request, word address (low 2 bits ignored)
//   if_ack/if_rdata       : one-cycle ack with the fetched word
//   d_req/d_we/d_addr/
//   d_wdata               : data request (d_we=1 store, 0 load)
//   d_ack/d_rdata         : one-cycle ack, load data
//   ram_r_wn/ram_addr/
//   ram_wdata/ram_rdata   : RAM side (1=read, 0=write; rdata one cycle late)
//   busy                  : high whenever the FSM is not in IDLE
//
// Configuration
//   MEM_ARB_RR_EN : when defined, contention is resolved round-robin using a
//                   1-bit last-grant pointer (reset = fetch). When undefined,
//                   the data port has fixed priority over fetch.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [11:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [11:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        ram_r_wn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT  = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        port_q, port_d;      // 1 = data port, 0 = fetch port
  logic        we_q, we_d;
  logic [11:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        ram_r_wn_q, ram_r_wn_d;

  logic        gnt_d;
  logic        gnt_i;
  logic [1:0]  cap_byte;
  logic [4:0]  cap_lsb;
  logic [4:0]  wr_lsb;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
  // Pointer records the port granted last: 0 = fetch, 1 = data.
  logic last_q, last_d;

  always_comb begin
    gnt_d = d_req;
    if (d_req && if_req) begin
      gnt_d = (last_q == 1'b0);
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (gnt_d || gnt_i)) begin
      last_d = gnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    gnt_d = d_req;
  end
`endif

  assign gnt_i = if_req & ~gnt_d;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // Byte captured in this cycle belongs to the previous beat.
  assign cap_byte = cnt_q - 2'd1;
  assign cap_lsb  = {cap_byte, 3'b000};
  assign wr_lsb   = {cnt_d, 3'b000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    we_d        = we_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_r_wn_d  = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          port_d  = 1'b1;
          we_d    = d_we;
          base_d  = d_addr & 12'hFFC;
          wdata_d = d_wdata;
          cnt_d   = '0;
          state_d = BEAT;
        end else if (gnt_i) begin
          port_d  = 1'b0;
          we_d    = 1'b0;
          base_d  = if_addr & 12'hFFC;
          wdata_d = '0;
          cnt_d   = '0;
          state_d = BEAT;
        end
      end

      BEAT: begin
        if (!we_q && cnt_q != 2'd0) begin
          rdata_d[cap_lsb +: 8] = ram_rdata;
        end
        if (cnt_q == 2'd3) begin
          cnt_d   = '0;
          state_d = we_q ? RESP : FLUSH;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      FLUSH: begin
        rdata_d[31:24] = ram_rdata;
        state_d        = RESP;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // RAM-side outputs are registered so they line up with the state they
    // belong to; outside BEAT the address and write data simply hold.
    if (state_d == BEAT) begin
      ram_addr_d  = base_d + {10'd0, cnt_d};
      ram_r_wn_d  = ~we_d;
      ram_wdata_d = {24'd0, wdata_d[wr_lsb +: 8]};
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_r_wn_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_r_wn_q  <= ram_r_wn_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy      = (state_q != IDLE);
  assign if_ack    = (state_q == RESP) && !port_q;
  assign d_ack     = (state_q == RESP) &&  port_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_r_wn  = ram_r_wn_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: if_req  in  1, if_addr  in  12, if_ack  out  1, if_rdata  out  32  (instruction-fetch port, read-only).
REQ-004 SHALL have: d_req  in  1, d_we  in  1, d_addr  in  12, d_wdata  in  32, d_ack  out  1, d_rdata  out  32  (data load/store port).
REQ-005 SHALL have: ram_r_wn  out  1, ram_addr  out  12, ram_wdata  out  32, ram_rdata  in  8  (byte-wide RAM; 1 = read, 0 = write; read data registered one cycle after address).
REQ-006 SHALL have: busy  out  1  (high whenever state is not IDLE).

Function
REQ-007 SHALL share one byte-wide RAM between both ports, moving one 32-bit word as 4 byte beats.
REQ-008 SHALL ignore addr[1:0]; base = {addr[11:2],2'b00}; beat i uses base+i, i=0..3, so no address wrap occurs (word 0xFFC uses bytes 0xFFC..0xFFF).
REQ-009 SHALL be little-endian: byte base+i maps to word bits [8i+7:8i].
REQ-010 SHALL use FSM states IDLE, BEAT, FLUSH, RESP; a 2-bit beat counter counts within BEAT.
REQ-011 IDLE: a request is sampled only in IDLE; on a grant, latch port id, d_we (0 for fetch), base and wdata, then go to BEAT with counter=0.
REQ-012 BEAT: drive ram_addr=base+counter; ram_r_wn=~we; ram_wdata={24'b0, wdata byte[counter]}; after counter=3, go to FLUSH on a read, or RESP on a write.
REQ-013 Read capture: in the cycle after beat i, ram_rdata SHALL be stored into byte i of the read-data register (beats 0..2 captured in BEAT, beat 3 captured in FLUSH).
REQ-014 FLUSH: ram_r_wn=1; capture byte 3; go to RESP.
REQ-015 RESP: pulse the granted port's ack high for exactly one cycle; return to IDLE.
REQ-016 Latency from acceptance edge (cycle 0): write ack SHALL occur in cycle 5; read ack SHALL occur in cycle 6.
REQ-017 A new request SHALL be accepted no earlier than the IDLE cycle after RESP, giving a minimum of 1 idle cycle between transactions.
REQ-018 if_rdata/d_rdata SHALL both be driven from the shared read-data register; they are valid only while the matching ack is high.
REQ-019 Requesters SHALL hold req and their fields stable until ack; the arbiter SHALL NOT sample fields after grant.
REQ-020 Outside BEAT, ram_r_wn SHALL be 1 and ram_addr SHALL hold its last value, so no RAM write occurs.
REQ-021 Arbitration (default): the data port SHALL win when both requests are high in IDLE.
REQ-022 A write on the data port SHALL produce no RAM activity beyond its 4 beats; read data register SHALL be left unchanged by writes.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, counter=0, if_ack=0, d_ack=0, busy=0, ram_r_wn=1, ram_addr=0, ram_wdata=0, read-data register=0.
REQ-024 If reset occurs mid-write, bytes already written SHALL remain in RAM, no ack SHALL be issued, and the requester SHALL reissue the request.
REQ-025 The first arbitration decision after reset SHALL favour the data port.

Configuration
REQ-026 Macro MEM_ARB_RR_EN: when defined, contention SHALL be resolved round-robin using a 1-bit last-grant pointer (reset = fetch), so that the port not granted last wins.
REQ-027 Without MEM_ARB_RR_EN, the design SHALL use fixed data-over-fetch priority and SHALL contain no pointer.

Verification
REQ-028 Data write d_addr=0x010, d_wdata=0xA1B2C3D4 -> RAM bytes 0x010..0x013 = D4,C3,B2,A1; d_ack in cycle 5; ram_r_wn low for exactly 4 cycles.
REQ-029 Fetch if_addr=0x013 after REQ-028 -> reads bytes 0x010..0x013; if_rdata=0xA1B2C3D4 with if_ack in cycle 6.
REQ-030 if_req and d_req held high together for 4 transactions -> default order is D,D,D,D, with fetch starved; under MEM_ARB_RR_EN, order is D,I,D,I.
REQ-031 Word at 0xFFC written with 0x11223344, then read -> 0x11223344, with no access to address 0x000.
REQ-032 rst asserted during beat 2 of a write of 0xDEADBEEF to 0x020 -> outputs reach reset values immediately, bytes 0x020..0x021 = EF,BE, no ack, next request is served normally.
